// File: rtl/mil1553_pkg.sv
// Shared constants, state type and Manchester helper for the MIL-STD-1553 transmit path.
package mil1553_pkg;

    localparam logic [5:0] SYNC_CMD           = 6'b111000;
    localparam logic [5:0] SYNC_DATA          = 6'b000111;
    localparam int         HALF_BITS_PER_WORD = 40;
    localparam int         DATA_BITS          = 16;
    localparam int         HALF_BIT_RATE      = 2000000;
    localparam logic [1:0] TX_H               = 2'b10;
    localparam logic [1:0] TX_L               = 2'b01;
    localparam logic [1:0] TX_OFF             = 2'b00;

    typedef enum logic {
        IDLE,
        TX
    } state_t;

    // Half-bit pattern, 1 = H: a data one is sent as H then L, a zero as L then H.
    function automatic logic [2*DATA_BITS-1:0] manchester16(input logic [DATA_BITS-1:0] d);
        logic [2*DATA_BITS-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BITS; i++) begin
            m[2*i +: 2] = d[i] ? 2'b10 : 2'b01;
        end
        return m;
    endfunction

endpackage

// File: rtl/axis_1553_encoder_if.sv
// AXI-stream word channel feeding the 1553 encoder: 16-bit payload plus sync/inject sideband.
interface axis_1553_encoder_if;
    import mil1553_pkg::*;

    logic [DATA_BITS-1:0] tdata;
    logic [1:0]           tuser;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, output tuser, output tvalid, input tready);
    modport slave  (input tdata, input tuser, input tvalid, output tready);

endinterface

// File: rtl/mil1553_halfbit_tick.sv
// Free-running half-bit timer: wraps at HALF_BIT_CNT-1, restarts on a word load.
// pre_tick flags the cycle before the wrap so ready can be registered; HALF_BIT_CNT must be >= 2.
module mil1553_halfbit_tick #(
    parameter int HALF_BIT_CNT = 50
) (
    input  logic aclk,
    input  logic arst,
    input  logic restart,
    output logic tick,
    output logic pre_tick
);

    localparam int            CW   = (HALF_BIT_CNT > 1) ? $clog2(HALF_BIT_CNT) : 1;
    localparam logic [CW-1:0] LAST = CW'(HALF_BIT_CNT - 1);
    localparam logic [CW-1:0] PREV = CW'(HALF_BIT_CNT - 2);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        if (restart || cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick     = (cnt_q == LAST);
    assign pre_tick = (cnt_q == PREV);

endmodule

// File: rtl/axis_1553_encoder.sv
// MIL-STD-1553 Manchester II word transmitter: AXI-stream words in, PMOD TX pair and enable out.
// Build option PARITY_ERR_EN: tuser[1] flips the parity bit to force a bus parity error.
module axis_1553_encoder
    import mil1553_pkg::*;
#(
    parameter int CLOCK_SPEED = 100000000
) (
    input  logic                aclk,
    input  logic                arst,
    axis_1553_encoder_if.slave  s_axis,
    output logic [1:0]          tx_diff,
    output logic                tx_en
);

    localparam int         HALF_BIT_CNT = CLOCK_SPEED / HALF_BIT_RATE;
    localparam logic [5:0] LAST_IDX     = 6'(HALF_BITS_PER_WORD - 1);

    state_t                          state_q, state_d;
    logic [HALF_BITS_PER_WORD-1:0]   shreg_q, shreg_d;
    logic [5:0]                      idx_q, idx_d;
    logic                            tx_en_q, tx_en_d;
    logic [1:0]                      tx_diff_q, tx_diff_d;
    logic                            tready_q, tready_d;

    logic                            handshake;
    logic                            parity;
    logic [HALF_BITS_PER_WORD-1:0]   pattern;
    logic                            tick;
    logic                            pre_tick;

    assign handshake = s_axis.tvalid & tready_q;

    mil1553_halfbit_tick #(
        .HALF_BIT_CNT (HALF_BIT_CNT)
    ) u_tick (
        .aclk     (aclk),
        .arst     (arst),
        .restart  (handshake),
        .tick     (tick),
        .pre_tick (pre_tick)
    );

    always_comb begin
        parity = ~^s_axis.tdata;
`ifdef PARITY_ERR_EN
        parity = parity ^ s_axis.tuser[1];
`else
`endif
        pattern = {(s_axis.tuser[0] ? SYNC_CMD : SYNC_DATA),
                   manchester16(s_axis.tdata),
                   parity, ~parity};
    end

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        idx_d     = idx_q;
        tx_en_d   = tx_en_q;
        tx_diff_d = tx_diff_q;
        tready_d  = tready_q;
        case (state_q)
            IDLE: begin
                tready_d  = 1'b1;
                tx_en_d   = 1'b0;
                tx_diff_d = TX_OFF;
                idx_d     = '0;
                if (handshake) begin
                    state_d   = TX;
                    shreg_d   = pattern;
                    idx_d     = '0;
                    tx_en_d   = 1'b1;
                    tx_diff_d = pattern[HALF_BITS_PER_WORD-1] ? TX_H : TX_L;
                    tready_d  = 1'b0;
                end
            end
            TX: begin
                // Ready is offered only in the last cycle of the final half-bit.
                tready_d = (idx_q == LAST_IDX) && pre_tick;
                if (tick) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d     = idx_q + 6'd1;
                        shreg_d   = shreg_q << 1;
                        tx_diff_d = shreg_q[HALF_BITS_PER_WORD-2] ? TX_H : TX_L;
                    end else if (handshake) begin
                        shreg_d   = pattern;
                        idx_d     = '0;
                        tx_en_d   = 1'b1;
                        tx_diff_d = pattern[HALF_BITS_PER_WORD-1] ? TX_H : TX_L;
                        tready_d  = 1'b0;
                    end else begin
                        state_d   = IDLE;
                        idx_d     = '0;
                        tx_en_d   = 1'b0;
                        tx_diff_d = TX_OFF;
                        tready_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                tx_en_d   = 1'b0;
                tx_diff_d = TX_OFF;
                tready_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge aclk or posedge arst) begin
        if (arst) begin
            state_q   <= IDLE;
            shreg_q   <= '0;
            idx_q     <= '0;
            tx_en_q   <= 1'b0;
            tx_diff_q <= TX_OFF;
            tready_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            shreg_q   <= shreg_d;
            idx_q     <= idx_d;
            tx_en_q   <= tx_en_d;
            tx_diff_q <= tx_diff_d;
            tready_q  <= tready_d;
        end
    end

    assign tx_diff       = tx_diff_q;
    assign tx_en         = tx_en_q;
    assign s_axis.tready = tready_q;

endmodule

// File: tb/tb_axis_1553_encoder.sv
// Scoreboard bench for axis_1553_encoder: expected half-bit patterns queued on handshake, checked per half-bit.
`timescale 1ns/1ps
module tb_axis_1553_encoder;

    localparam int CLK_HZ   = 100000000;
    localparam int HB       = 50;
    localparam int WORD_CYC = 40 * HB;

    logic       aclk = 1'b0;
    logic       arst = 1'b1;
    logic [1:0] tx_diff;
    logic       tx_en;

    axis_1553_encoder_if s_axis ();

    axis_1553_encoder #(
        .CLOCK_SPEED (CLK_HZ)
    ) dut (
        .aclk    (aclk),
        .arst    (arst),
        .s_axis  (s_axis.slave),
        .tx_diff (tx_diff),
        .tx_en   (tx_en)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [39:0] model(input logic [15:0] d, input logic [1:0] u);
        logic [39:0] p;
        logic        par;
        p   = {34'b0, (u[0] ? 6'b111000 : 6'b000111)};
        par = 1'b1;
        for (int i = 15; i >= 0; i--) begin
            p   = {p[37:0], d[i], ~d[i]};
            par = par ^ d[i];
        end
`ifdef PARITY_ERR_EN
        par = par ^ u[1];
`endif
        p = {p[37:0], par, ~par};
        return p;
    endfunction

    logic [39:0] exp_q[$];
    int          start_cyc[$];
    logic        active = 1'b0;
    logic [39:0] cur;
    int          hb = 0, cyc = 0, good = 0;
    int          en_len = 0, burst_words = 0, cyc_cnt = 0;
    int          tr_cnt = 0;
    logic        idle_watch = 1'b0;
    int          idle_bad = 0;

    always @(negedge aclk) begin
        cyc_cnt++;
        if (idle_watch && !(tx_en === 1'b0 && tx_diff === 2'b00 && s_axis.tready === 1'b1))
            idle_bad++;
        if (arst) begin
            active      = 1'b0;
            exp_q.delete();
            en_len      = 0;
            burst_words = 0;
        end else begin
            if (tx_en && s_axis.tready) tr_cnt++;
            if (tx_en) en_len++;
            if (!active && tx_en) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_tx", {31'b0, tx_en}, 32'd0);
                end else begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    hb     = 0;
                    cyc    = 0;
                    good   = 0;
                    burst_words++;
                    start_cyc.push_back(cyc_cnt);
                end
            end
            if (active) begin
                if (tx_en === 1'b1 && tx_diff === (cur[39-hb] ? 2'b10 : 2'b01)) good++;
                cyc++;
                if (cyc == HB) begin
                    chk($sformatf("halfbit%0d_good_cycles", hb), good, HB);
                    hb++;
                    cyc  = 0;
                    good = 0;
                    if (hb == 40) active = 1'b0;
                end
            end
            if (!tx_en && en_len > 0) begin
                chk("tx_en_len", en_len, burst_words * WORD_CYC);
                chk("off_level", {30'b0, tx_diff}, 32'd0);
                en_len      = 0;
                burst_words = 0;
            end
        end
    end

    task automatic send(input logic [15:0] d, input logic [1:0] u, input bit hold);
        int waited;
        waited = 0;
        @(negedge aclk);
        s_axis.tdata  = d;
        s_axis.tuser  = u;
        s_axis.tvalid = 1'b1;
        while (s_axis.tready !== 1'b1 && waited < 5000) begin
            @(negedge aclk);
            waited++;
        end
        if (s_axis.tready !== 1'b1) begin
            chk("tready_timeout", {31'b0, s_axis.tready}, 32'd1);
            s_axis.tvalid = 1'b0;
            return;
        end
        exp_q.push_back(model(d, u));
        @(negedge aclk);
        if (!hold) begin
            s_axis.tvalid = 1'b0;
            s_axis.tdata  = 16'($urandom);
            s_axis.tuser  = 2'($urandom);
        end
    endtask

    task automatic wait_idle();
        int waited;
        waited = 0;
        while ((exp_q.size() != 0 || active || tx_en) && waited < 10000) begin
            @(negedge aclk);
            waited++;
        end
        chk("idle_timeout", waited < 10000 ? 32'd1 : 32'd0, 32'd1);
        @(negedge aclk);
    endtask

    initial begin
        s_axis.tdata  = '0;
        s_axis.tuser  = '0;
        s_axis.tvalid = 1'b0;

        repeat (3) @(negedge aclk);
        chk("rst_tx_diff", {30'b0, tx_diff}, 32'd0);
        chk("rst_tx_en", {31'b0, tx_en}, 32'd0);
        chk("rst_tready", {31'b0, s_axis.tready}, 32'd0);
        arst = 1'b0;
        #1 chk("tready_before_edge", {31'b0, s_axis.tready}, 32'd0);
        @(negedge aclk);
        chk("tready_after_rst", {31'b0, s_axis.tready}, 32'd1);

        // Single words: command sync on zeros, data sync on ones.
        send(16'h0000, 2'b01, 1'b0);
        wait_idle();
        send(16'hFFFF, 2'b00, 1'b0);
        wait_idle();

        // Back-to-back with tvalid held.
        start_cyc.delete();
        tr_cnt = 0;
        send(16'hA5A5, 2'b01, 1'b1);
        send(16'h1234, 2'b00, 1'b0);
        wait_idle();
        chk("b2b_words", start_cyc.size(), 32'd2);
        if (start_cyc.size() == 2)
            chk("b2b_gap", start_cyc[1] - start_cyc[0], WORD_CYC);
        chk("b2b_tready_pulses", tr_cnt, 32'd2);

        // Reset in the middle of a word.
        send(16'h5555, 2'b01, 1'b0);
        begin : wait_hb20
            int waited;
            waited = 0;
            while (!(active && hb == 20) && waited < 5000) begin
                @(negedge aclk);
                waited++;
            end
            chk("reach_hb20", waited < 5000 ? 32'd1 : 32'd0, 32'd1);
        end
        @(posedge aclk);
        #2 arst = 1'b1;
        #1;
        chk("arst_tx_diff", {30'b0, tx_diff}, 32'd0);
        chk("arst_tx_en", {31'b0, tx_en}, 32'd0);
        chk("arst_tready", {31'b0, s_axis.tready}, 32'd0);
        repeat (3) @(negedge aclk);
        arst = 1'b0;
        #1 chk("tready_rel_before_edge", {31'b0, s_axis.tready}, 32'd0);
        @(negedge aclk);
        chk("tready_rel", {31'b0, s_axis.tready}, 32'd1);
        send(16'h0001, 2'b00, 1'b0);
        wait_idle();

        // Parity inject request; odd parity unless the inject build option is present.
        send(16'h0001, 2'b11, 1'b0);
        wait_idle();

        // Long idle.
        s_axis.tvalid = 1'b0;
        idle_bad   = 0;
        idle_watch = 1'b1;
        repeat (10000) @(negedge aclk);
        idle_watch = 1'b0;
        chk("idle_violations", idle_bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
